// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and core-protocol constants for the GCD requester.
package gcd_pkg;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, OUT} gcd_req_state_t;

    // The core loads A in the start cycle and B this many cycles later.
    localparam int CORE_B_LAG = 1;

endpackage

// File: rtl/gcd_wait_timer.sv
// gcd_wait_timer: counts WAIT cycles and flags when the done deadline is reached.
module gcd_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end

    assign expired = cnt == W'(TIMEOUT - 1);

endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: feeds operand pairs to the subtraction GCD core and returns results,
// short-circuiting zero operands and bounding the wait for done.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result
);

    gcd_req_state_t state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic accept, expired;

    assign accept = in_valid && state == IDLE;

    gcd_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state != WAIT),
        .en(state == WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !in_valid ? IDLE : (in_a != '0 && in_b != '0) ? SEND_A : OUT;
            SEND_A:  state_nxt = SEND_B;
            SEND_B:  state_nxt = WAIT;
            WAIT:    state_nxt = (core_done || expired) ? OUT : WAIT;
            OUT:     state_nxt = out_ready ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = state == IDLE;
        out_valid  = state == OUT;
        core_start = state == SEND_A;
        core_data  = state == SEND_A ? a_q : state == SEND_B ? b_q : '0;
    end

    // Done is only honoured in WAIT, so a level left high by the previous run is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            out_gcd <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            out_gcd <= in_a | in_b;
            out_err <= in_a == '0 && in_b == '0;
        end else if (state == WAIT && core_done) begin
            out_gcd <= core_result;
            out_err <= 1'b0;
        end else if (state == WAIT && expired) begin
            out_gcd <= '0;
            out_err <= 1'b1;
        end
    end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Host-side initiator for the subtraction-based GCD core. It accepts operand pairs from a host over a valid/ready handshake and serialises each pair onto the core's start/data bus. It then waits for the core's done, returns the result over a second valid/ready handshake, and guards against the two things that hang the core: zero operands and missing done.

## Interface

- WIDTH, 16: operand and result width in bits.
- TIMEOUT, 1024: maximum WAIT cycles allowed before done; must be ≥1.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  host presents an operand pair.
- in_ready  output  1  requester can accept a pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  host accepts the result.
- out_gcd  output  WIDTH  GCD result, or 0 on error.
- out_err  output  1  result is invalid: timeout, or both operands 0.
- core_start  output  1  one-cycle pulse; the core loads core_data as A in this cycle.
- core_data  output  WIDTH  A in the start cycle, B in the next cycle, 0 otherwise.
- core_done  input  1  core level signal; the core clears it when it loads A.
- core_result  input  WIDTH  core's A register, valid while core_done=1.

## Operation

- States: IDLE, SEND_A, SEND_B, WAIT, OUT.
- in_ready=1 only in IDLE. A transfer occurs when in_valid & in_ready; in_a and in_b are latched on that cycle.
- IDLE, on accept:
  - a≠0 and b≠0 → SEND_A.
  - exactly one operand is 0 → OUT, with out_gcd = the nonzero operand and out_err=0.
  - both are 0 → OUT, with out_gcd=0 and out_err=1. No core transaction occurs.
- SEND_A: core_start=1, core_data=a → SEND_B.
- SEND_B: core_start=0, core_data=b → WAIT.
- WAIT: core_data=0. Each cycle:
  - core_done=1 → capture core_result into out_gcd, out_err=0 → OUT.
  - else, if the timeout counter = TIMEOUT-1 → out_gcd=0, out_err=1 → OUT.
  - else, increment the counter.
- The counter clears on entering WAIT. It is $clog2(TIMEOUT+1) bits wide.
- core_done and timeout in the same cycle: done wins.
- core_done is ignored in SEND_A and SEND_B. A stale done still high from the previous operation must not complete the new one.
- OUT: out_valid=1. out_gcd and out_err are held stable until out_ready=1, then → IDLE. in_ready rises the cycle after the handshake.
- After a timeout the core is left running. The next SEND_A restarts it.
- Reset (any state, including WAIT or OUT):
  - next cycle: state=IDLE.
  - all outputs 0 except in_ready=1.
  - counter=0.
  - any in-flight operation and pending result are discarded.
- rst overrides every other input in the same cycle.

## Timing

- Accept at cycle T.
- core_start=1 at T+1 (core_data=a); core_data=b at T+2; WAIT from T+3.
- core_done first seen at cycle D ≥ T+3 → out_valid=1 at D+1.
- Zero-operand bypass: out_valid=1 at T+1.
- Timeout with no done: out_valid=1 at T+3+TIMEOUT.
- Throughput: one operation in flight. Back-to-back minimum period is 5 cycles: accept, SEND_A, SEND_B, WAIT, OUT. This requires core_done at T+3 and out_ready=1 in the first OUT cycle.
- All outputs are registered. No combinational path from any input to any output.

## Structure

- Shared package gcd_pkg holds:
  - state enum gcd_req_state_t (IDLE, SEND_A, SEND_B, WAIT, OUT);
  - the core protocol constant that A is loaded in the start cycle and B one cycle later.
- Sub-module gcd_wait_timer (parameter TIMEOUT; ports clr, en, expired) implements the WAIT counter. The FSM, the operand latches and the result register stay in gcd_requester.

## Test plan

- Nominal: (48,18); behavioural core asserts done with result 6 ten cycles into WAIT.
  - core_start high for exactly 1 cycle with core_data=48, then core_data=18.
  - out_valid 1 cycle after done, out_gcd=6, out_err=0.
- Bypass: (0,35) → out_gcd=35, out_err=0 at T+1, core_start never asserted. (0,0) → out_gcd=0, out_err=1.
- Timeout: TIMEOUT=16, core never asserts done → out_valid at T+19, out_gcd=0, out_err=1. Next pair (9,6) completes normally with 3.
- Stale done: core_done held 1 through SEND_A and SEND_B, core clears it at T+3, real done at T+8 with 5 → out_gcd=5 at T+9, not the stale value.
- Backpressure: out_ready low for 5 cycles.
  - out_valid, out_gcd and out_err stable; in_ready=0 throughout.
  - Then back-to-back pairs (12,8), (7,7) → 4, 7 in order.
- Reset mid-WAIT: rst for 1 cycle.
  - Next cycle: IDLE, in_ready=1, out_valid=0, core_start=0, core_data=0.
  - A later done from the abandoned op produces no output.
